// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of the imem loader.
// The loader uses the master view; source/memory model use slave.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a high-byte-first stream into
// 16-bit words at addresses 0..count-1 while holding the CPU.
module imem_loader #(
  parameter int ADDR_WIDTH    = 4,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_WIDTH:0] word_count,
  imem_loader_if.master       bus,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    WR,
    FIN
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE = 1;

  state_t                state;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [7:0]            hi;

  logic xfer;
  logic last;
  logic start_ok;

  assign xfer     = bus.in_valid && bus.in_ready;
  assign last     = ({1'b0, waddr} + ONE) == count;
  assign start_ok = (word_count != '0) &&
                    (word_count <= DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      waddr         <= '0;
      hi            <= '0;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_hold      <= HOLD_AT_RESET;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      err  <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && start_ok) begin
            count        <= word_count;
            waddr        <= '0;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
            bus.in_ready <= 1'b1;
            state        <= HI;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        HI: begin
          if (xfer) begin
            hi    <= bus.in_data;
            state <= LO;
          end
        end
        LO: begin
          // Present the write directly so mem_we is high in WR.
          if (xfer) begin
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= waddr;
            bus.mem_wdata <= {hi, bus.in_data};
            state         <= WR;
          end
        end
        WR: begin
          bus.mem_we <= 1'b0;
          if (last) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            waddr        <= waddr + 1'b1;
            bus.in_ready <= 1'b1;
            state        <= HI;
          end
        end
        FIN: begin
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
